decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parameterised MIPS instruction-decode pipeline stage between fetch and execute.
- Contains the architectural register file: two read ports and one writeback port.
- Extracts instruction fields and extends the 16-bit immediate.
- Detects load-use hazards and drives a stall to fetch; one-cycle pipeline register with valid/stall/flush control.

Parameters:
DATA_W, 32, register/operand width in bits; legal range 16..64.
NUM_REGS, 32, register count; power of two, 8..32; register indices are the low log2(NUM_REGS) bits of the 5-bit fields.
BYPASS, 1, 1 = writeback-to-read bypass enabled; 0 = reads return register-file contents only.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
instr_valid_in  input  1  instruction_in holds a valid instruction
instruction_in  input  32  instruction word from fetch
stall_in  input  1  execute cannot accept; hold outputs
flush_in  input  1  kill the instruction entering the pipeline register (branch/jump redirect)
wb_en_in  input  1  writeback enable
wb_addr_in  input  5  writeback register index
wb_data_in  input  DATA_W  writeback data
ex_load_in  input  1  instruction currently in execute is a load
ex_dest_in  input  5  destination register of that instruction
valid_out  output  1  decode outputs hold a valid instruction
data1_out  output  DATA_W  rs operand
data2_out  output  DATA_W  rt operand
imm_out  output  DATA_W  extended immediate
opcode_out  output  6  instr[31:26]
funcode_out  output  6  instr[5:0]
rs_out  output  5  instr[25:21]
rt_out  output  5  instr[20:16]
rd_out  output  5  instr[15:11]
shamt_out  output  5  instr[10:6]
stall_out  output  1  to fetch: hold instruction_in

Behaviour:
- Reset: asynchronous; all outputs and all registers go to 0 immediately and stay 0 while reset is high.
- Register file:
  - Register 0 always reads 0; writes to it are ignored.
  - Write on the rising clock edge when wb_en_in=1 and index!=0.
  - The write happens regardless of stall_in, flush_in or hazard.
- Read (combinational), for rs and rt independently:
  - If BYPASS=1, wb_en_in=1, wb index==read index and index!=0: use wb_data_in.
  - Otherwise use the register-file contents.
- Immediate:
  - Opcodes 0x0C, 0x0D, 0x0E (andi, ori, xori): zero-extend instr[15:0] to DATA_W.
  - All other opcodes: sign-extend instr[15:0] to DATA_W.
- uses_rt = opcode 0x00 or 0x04 or 0x05 or 0x2B.
- hazard = instr_valid_in & ex_load_in & ex_dest_in!=0 & (ex_dest_in==rs | (uses_rt & ex_dest_in==rt)).
- stall_out = hazard | stall_in (combinational).
- Pipeline register update per edge, in priority order:
  1. flush_in: valid_out<=0; other fields don't-care (implementation holds them).
  2. stall_in: all outputs hold. If BYPASS=1 and wb_en_in writes a nonzero index equal to held rs_out (rt_out), data1_out (data2_out) takes wb_data_in, so held operands never go stale.
  3. hazard: bubble inserted, valid_out<=0; fetch holds the instruction, which is re-decoded next cycle.
  4. Normal: valid_out<=instr_valid_in; all fields and operands captured.
- Latency: one cycle from instruction_in to registered outputs.
- Simultaneous flush_in and stall_in: flush wins, valid_out=0.
- Reset deasserted mid-sequence: the first edge after release behaves as normal load.
- DATA_W<32: wb_data_in and operands are truncated to DATA_W; the immediate is still extended from bit 15 (sign-extend when DATA_W=16 is identity).
- NUM_REGS<32: indices alias modulo NUM_REGS.
- Index 0 guard: rs_out/rt_out compare uses full 5 bits; register-file indexing uses the truncated index.

Test Plan:
- Reset: write r5=0x1234 then assert reset -> all outputs 0 at once; after release, reading r5 returns 0.
- Basic R-type: r1=7, r2=9, instruction 0x00221820 (add r3,r1,r2) -> next cycle: valid_out=1, data1_out=7, data2_out=9, opcode_out=0, funcode_out=0x20, rd_out=3.
- Immediate extension: ori r1,r0,0x8000 -> imm_out=0x00008000; addi r1,r0,0x8000 -> imm_out=0xFFFF8000; write to r0 -> r0 still reads 0.
- Bypass and stall refresh: same-cycle wb r4=0xAA while decoding rs=4 -> data1_out=0xAA. With stall_in held and held rt_out=6, wb r6=0x55 -> data2_out=0x55 while other outputs stay unchanged.
- Load-use hazard: ex_load_in=1, ex_dest_in=2, decode add r3,r1,r2 -> stall_out=1 and valid_out=0 for one cycle; next cycle ex_load_in=0 -> valid_out=1. The same case with addi using rt=2 as destination -> no stall.
- Flush priority: flush_in=1 together with stall_in=1 and a valid instruction -> valid_out=0 next cycle, and a pending writeback still lands in the register file.

Source files
------------

// File: rtl/decode_stage.sv
// MIPS decode stage: register file with optional writeback bypass, field
// extraction, immediate extension, load-use hazard stall and pipeline register.
module decode_stage #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter bit BYPASS   = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid_in,
    input  logic [31:0]       instruction_in,
    input  logic              stall_in,
    input  logic              flush_in,
    input  logic              wb_en_in,
    input  logic [4:0]        wb_addr_in,
    input  logic [DATA_W-1:0] wb_data_in,
    input  logic              ex_load_in,
    input  logic [4:0]        ex_dest_in,
    output logic              valid_out,
    output logic [DATA_W-1:0] data1_out,
    output logic [DATA_W-1:0] data2_out,
    output logic [DATA_W-1:0] imm_out,
    output logic [5:0]        opcode_out,
    output logic [5:0]        funcode_out,
    output logic [4:0]        rs_out,
    output logic [4:0]        rt_out,
    output logic [4:0]        rd_out,
    output logic [4:0]        shamt_out,
    output logic              stall_out
);

    localparam int IDX_W = $clog2(NUM_REGS);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_SW    = 6'h2B;

    logic [DATA_W-1:0] regs [NUM_REGS];

    logic [5:0]        opcode;
    logic [4:0]        rs, rt;
    logic [IDX_W-1:0]  rs_idx, rt_idx, wb_idx;
    logic [DATA_W-1:0] rd1, rd2, imm;
    logic              uses_rt, hazard;
    logic              wb_live, refresh1, refresh2;

    assign opcode = instruction_in[31:26];
    assign rs     = instruction_in[25:21];
    assign rt     = instruction_in[20:16];
    assign rs_idx = instruction_in[21 +: IDX_W];
    assign rt_idx = instruction_in[16 +: IDX_W];
    assign wb_idx = wb_addr_in[IDX_W-1:0];

    // Register 0 is never written, so its storage stays at its reset value of 0.
    // NOTE: this array is reset explicitly because reset must clear architectural state;
    // a plain RAM would normally be left unreset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wb_en_in && wb_idx != '0) begin
            regs[wb_idx] <= wb_data_in;
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        rd1 = regs[rs_idx];
        rd2 = regs[rt_idx];
        if (BYPASS && wb_en_in && wb_idx != '0) begin
            if (wb_idx == rs_idx) rd1 = wb_data_in;
            if (wb_idx == rt_idx) rd2 = wb_data_in;
        end
    end

    always_comb begin
        imm = DATA_W'($signed(instruction_in[15:0]));
        if (opcode == OP_ANDI || opcode == OP_ORI || opcode == OP_XORI)
            imm = DATA_W'(instruction_in[15:0]);
    end

    assign uses_rt = (opcode == OP_RTYPE) || (opcode == OP_BEQ) ||
                     (opcode == OP_BNE)   || (opcode == OP_SW);
    assign hazard  = instr_valid_in && ex_load_in && ex_dest_in != 5'd0 &&
                     (ex_dest_in == rs || (uses_rt && ex_dest_in == rt));

    // Gated so every output reads 0 while reset is held.
    assign stall_out = !reset && (hazard || stall_in);

    // Held operands track writebacks to their register so they never go stale.
    assign wb_live  = BYPASS && wb_en_in && wb_addr_in != 5'd0;
    assign refresh1 = wb_live && wb_addr_in == rs_out;
    assign refresh2 = wb_live && wb_addr_in == rt_out;

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_out   <= 1'b0;
            data1_out   <= '0;
            data2_out   <= '0;
            imm_out     <= '0;
            opcode_out  <= '0;
            funcode_out <= '0;
            rs_out      <= '0;
            rt_out      <= '0;
            rd_out      <= '0;
            shamt_out   <= '0;
        end else if (flush_in) begin
            valid_out <= 1'b0;
        end else if (stall_in) begin
            if (refresh1) data1_out <= wb_data_in;
            if (refresh2) data2_out <= wb_data_in;
        end else if (hazard) begin
            valid_out <= 1'b0;
        end else begin
            valid_out   <= instr_valid_in;
            data1_out   <= rd1;
            data2_out   <= rd2;
            imm_out     <= imm;
            opcode_out  <= opcode;
            funcode_out <= instruction_in[5:0];
            rs_out      <= rs;
            rt_out      <= rt;
            rd_out      <= instruction_in[15:11];
            shamt_out   <= instruction_in[10:6];
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever valid_out is presented.
module tb_decode_stage;

    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic              instr_valid_in;
    logic [31:0]       instruction_in;
    logic              stall_in, flush_in;
    logic              wb_en_in;
    logic [4:0]        wb_addr_in;
    logic [DATA_W-1:0] wb_data_in;
    logic              ex_load_in;
    logic [4:0]        ex_dest_in;
    logic              valid_out;
    logic [DATA_W-1:0] data1_out, data2_out, imm_out;
    logic [5:0]        opcode_out, funcode_out;
    logic [4:0]        rs_out, rt_out, rd_out, shamt_out;
    logic              stall_out;

    typedef struct packed {
        logic [31:0] d1;
        logic [31:0] d2;
        logic [31:0] imm;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    decode_stage #(.DATA_W(DATA_W), .NUM_REGS(32), .BYPASS(1'b1)) dut (
        .clock(clock), .reset(reset),
        .instr_valid_in(instr_valid_in), .instruction_in(instruction_in),
        .stall_in(stall_in), .flush_in(flush_in),
        .wb_en_in(wb_en_in), .wb_addr_in(wb_addr_in), .wb_data_in(wb_data_in),
        .ex_load_in(ex_load_in), .ex_dest_in(ex_dest_in),
        .valid_out(valid_out), .data1_out(data1_out), .data2_out(data2_out),
        .imm_out(imm_out), .opcode_out(opcode_out), .funcode_out(funcode_out),
        .rs_out(rs_out), .rt_out(rt_out), .rd_out(rd_out), .shamt_out(shamt_out),
        .stall_out(stall_out)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [5:0] op,
                                input logic [5:0] fn, input logic [4:0] rs,
                                input logic [4:0] rt, input logic [4:0] rd,
                                input logic [4:0] sh);
        mk = '{d1: d1, d2: d2, imm: imm, op: op, fn: fn, rs: rs, rt: rt, rd: rd, sh: sh};
    endfunction

    // One clock edge; the expectation for what that edge captures is queued
    // before the following negedge, where the monitor consumes it.
    task automatic tick(input bit push_it, input exp_t e);
        @(posedge clock);
        if (push_it) sb.push_back(e);
        #1;
    endtask

    task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
        instr_valid_in = 1'b0;
        wb_en_in = 1'b1; wb_addr_in = a; wb_data_in = d;
        tick(1'b0, '0);
        wb_en_in = 1'b0;
    endtask

    task automatic decode(input logic [31:0] instr, input exp_t e);
        instr_valid_in = 1'b1; instruction_in = instr;
        tick(1'b1, e);
        instr_valid_in = 1'b0;
    endtask

    // Monitor: every presented valid instruction must match the oldest expectation.
    initial begin
        forever begin
            @(negedge clock);
            if (!reset && valid_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_valid", 64'(valid_out), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("data1", 64'(data1_out), 64'(e.d1));
                    check("data2", 64'(data2_out), 64'(e.d2));
                    check("imm",   64'(imm_out),   64'(e.imm));
                    check("opcode", 64'(opcode_out), 64'(e.op));
                    check("funcode", 64'(funcode_out), 64'(e.fn));
                    check("rs", 64'(rs_out), 64'(e.rs));
                    check("rt", 64'(rt_out), 64'(e.rt));
                    check("rd", 64'(rd_out), 64'(e.rd));
                    check("shamt", 64'(shamt_out), 64'(e.sh));
                end
            end
        end
    end

    initial begin
        reset = 1'b1;
        instr_valid_in = 1'b0; instruction_in = '0;
        stall_in = 1'b0; flush_in = 1'b0;
        wb_en_in = 1'b0; wb_addr_in = '0; wb_data_in = '0;
        ex_load_in = 1'b0; ex_dest_in = '0;
        tick(1'b0, '0);
        tick(1'b0, '0);
        check("reset_valid", 64'(valid_out), 64'd0);
        reset = 1'b0;

        // Reset: r5 is populated and an instruction is held, then reset strikes mid-cycle.
        wb_write(5'd5, 32'h1234);
        decode(32'h00A01820, mk(32'h1234, 32'h0, 32'h1820, 6'h00, 6'h20, 5'd5, 5'd0, 5'd3, 5'd0));
        @(negedge clock);
        stall_in = 1'b1;
        #1 reset = 1'b1;
        #1;
        check("async_reset_valid", 64'(valid_out), 64'd0);
        check("async_reset_data1", 64'(data1_out), 64'd0);
        check("async_reset_imm",   64'(imm_out),   64'd0);
        check("async_reset_rd",    64'(rd_out),    64'd0);
        check("async_reset_stall", 64'(stall_out), 64'd0);
        tick(1'b0, '0);
        check("held_reset_valid", 64'(valid_out), 64'd0);
        reset = 1'b0; stall_in = 1'b0;
        decode(32'h00A01820, mk(32'h0, 32'h0, 32'h1820, 6'h00, 6'h20, 5'd5, 5'd0, 5'd3, 5'd0));

        // Basic R-type: add r3,r1,r2.
        wb_write(5'd1, 32'd7);
        wb_write(5'd2, 32'd9);
        decode(32'h00221820, mk(32'd7, 32'd9, 32'h1820, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0));

        // Immediate extension: ori zero-extends, addi sign-extends, andi with all ones.
        decode(32'h34018000, mk(32'd0, 32'd7, 32'h00008000, 6'h0D, 6'h00, 5'd0, 5'd1, 5'd16, 5'd0));
        decode(32'h20018000, mk(32'd0, 32'd7, 32'hFFFF8000, 6'h08, 6'h00, 5'd0, 5'd1, 5'd16, 5'd0));
        decode(32'h3003FFFF, mk(32'd0, 32'd0, 32'h0000FFFF, 6'h0C, 6'h3F, 5'd0, 5'd3, 5'd31, 5'd31));

        // Write to r0 must neither bypass nor stick.
        wb_en_in = 1'b1; wb_addr_in = 5'd0; wb_data_in = 32'hDEAD;
        decode(32'h00000000, mk(32'd0, 32'd0, 32'd0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0));
        wb_en_in = 1'b0;
        decode(32'h00000000, mk(32'd0, 32'd0, 32'd0, 6'h00, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0));

        // Same-cycle bypass: wb r4=0xAA while decoding add r5,r4,r0.
        wb_en_in = 1'b1; wb_addr_in = 5'd4; wb_data_in = 32'hAA;
        decode(32'h00802820, mk(32'hAA, 32'd0, 32'h2820, 6'h00, 6'h20, 5'd4, 5'd0, 5'd5, 5'd0));
        wb_en_in = 1'b0;

        // Stall refresh: hold add r7,r4,r6 while r6 is written.
        decode(32'h00863820, mk(32'hAA, 32'd0, 32'h3820, 6'h00, 6'h20, 5'd4, 5'd6, 5'd7, 5'd0));
        stall_in = 1'b1; instr_valid_in = 1'b1; instruction_in = 32'hFFFFFFFF;
        wb_en_in = 1'b1; wb_addr_in = 5'd6; wb_data_in = 32'h55;
        #1 check("stall_out_from_stall_in", 64'(stall_out), 64'd1);
        tick(1'b1, mk(32'hAA, 32'h55, 32'h3820, 6'h00, 6'h20, 5'd4, 5'd6, 5'd7, 5'd0));
        wb_en_in = 1'b0;
        tick(1'b1, mk(32'hAA, 32'h55, 32'h3820, 6'h00, 6'h20, 5'd4, 5'd6, 5'd7, 5'd0));
        stall_in = 1'b0; instr_valid_in = 1'b0;
        tick(1'b0, '0);
        check("idle_after_stall", 64'(valid_out), 64'd0);

        // Load-use hazard on rt of an R-type.
        ex_load_in = 1'b1; ex_dest_in = 5'd2;
        instr_valid_in = 1'b1; instruction_in = 32'h00221820;
        #1 check("hazard_stall_out", 64'(stall_out), 64'd1);
        tick(1'b0, '0);
        check("hazard_bubble", 64'(valid_out), 64'd0);
        ex_load_in = 1'b0;
        #1 check("hazard_cleared", 64'(stall_out), 64'd0);
        decode(32'h00221820, mk(32'd7, 32'd9, 32'h1820, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd0));

        // addi r2,r1,5: rt is a destination, so a load to r2 is no hazard; a load to r1 is.
        ex_load_in = 1'b1; ex_dest_in = 5'd1;
        instr_valid_in = 1'b1; instruction_in = 32'h20220005;
        #1 check("hazard_on_rs", 64'(stall_out), 64'd1);
        ex_dest_in = 5'd2;
        #1 check("no_hazard_addi_rt", 64'(stall_out), 64'd0);
        decode(32'h20220005, mk(32'd7, 32'd9, 32'h5, 6'h08, 6'h05, 5'd1, 5'd2, 5'd0, 5'd0));
        ex_load_in = 1'b0;

        // Flush beats stall; the concurrent writeback still lands.
        flush_in = 1'b1; stall_in = 1'b1;
        instr_valid_in = 1'b1; instruction_in = 32'h00221820;
        wb_en_in = 1'b1; wb_addr_in = 5'd9; wb_data_in = 32'h99;
        tick(1'b0, '0);
        check("flush_over_stall", 64'(valid_out), 64'd0);
        flush_in = 1'b0; stall_in = 1'b0; wb_en_in = 1'b0;
        decode(32'h01200020, mk(32'h99, 32'd0, 32'h0020, 6'h00, 6'h20, 5'd9, 5'd0, 5'd0, 5'd0));

        tick(1'b0, '0);
        tick(1'b0, '0);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
